// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter: round-robin, one transfer per grant, registered grant state.
// Define WB_ARB_TIMEOUT_EN to build the bus-timeout watchdog (error pulse plus sticky timeout_o).
module wb_arbiter2 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]           m0_dat_i,
    output logic [31:0]           m0_dat_o,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic                  m0_stb_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]           m1_dat_i,
    output logic [31:0]           m1_dat_o,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic                  m1_stb_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [31:0]           s_dat_o,
    input  logic [31:0]           s_dat_i,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic                  s_ack_i,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   timeout_q, timeout_d;
    logic   expire_s;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT_CYCLES must lie in 2..65535");
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    // Watchdog: counter restarts on every grant and fires when it reaches the last allowed cycle.
    always_comb begin
        expire_s  = 1'b0;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            cnt_d = 16'd0;
        end else if (!s_ack_i) begin
            cnt_d     = cnt_q + 16'd1;
            expire_s  = (cnt_q == CNT_LAST);
            timeout_d = timeout_q | (cnt_q == CNT_LAST);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        expire_s  = 1'b0;
        timeout_d = 1'b0;
    end
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Contention goes to the master that did not hold the previous grant.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    if (last_gnt_q) begin
                        state_d    = GNT0;
                        last_gnt_d = 1'b0;
                    end else begin
                        state_d    = GNT1;
                        last_gnt_d = 1'b1;
                    end
                end else if (m0_stb_i) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_stb_i) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (s_ack_i || !m0_stb_i || expire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GNT0;
                end
            end
            GNT1: begin
                if (s_ack_i || !m1_stb_i || expire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = GNT1;
                end
            end
            default: begin
                state_d    = IDLE;
                last_gnt_d = last_gnt_q;
            end
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = 32'd0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'd0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_dat_o = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = 1'b1;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = expire_s;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = 1'b1;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = expire_s;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: per-cycle vector table plus hand sequences for async reset and the watchdog.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
    logic        m0_we, m0_stb, m0_ack, m0_err, m1_we, m1_stb, m1_ack, m1_err;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic        s_we, s_stb, s_cyc, s_ack, timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack),
        .timeout_o(timeout)
    );

    typedef struct {
        logic       rst, m0_stb, m1_stb, m1_we, s_ack;
        logic [3:0] e_flags;   // {s_stb, s_cyc, m0_ack, m1_ack}
        logic [1:0] src;       // 0 none, 1 master 0, 2 master 1
        logic       fair;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s0, input logic s1, input logic we,
                                input logic ack, input logic [3:0] e, input logic [1:0] src,
                                input logic fair);
        vec_t v;
        v.rst = r; v.m0_stb = s0; v.m1_stb = s1; v.m1_we = we; v.s_ack = ack;
        v.e_flags = e; v.src = src; v.fair = fair;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_route(input string nm, input logic [1:0] src);
        logic [31:0] e_adr, e_dat, e_d0, e_d1;
        logic        e_we;
        logic [3:0]  e_sel;
        e_adr = 32'd0; e_dat = 32'd0; e_we = 1'b0; e_sel = 4'd0; e_d0 = 32'd0; e_d1 = 32'd0;
        if (src == 2'd1) begin
            e_adr = m0_adr; e_dat = m0_dat_i; e_we = m0_we; e_sel = m0_sel; e_d0 = s_dat_i;
        end else if (src == 2'd2) begin
            e_adr = m1_adr; e_dat = m1_dat_i; e_we = m1_we; e_sel = m1_sel; e_d1 = s_dat_i;
        end
        chk({nm, ".s_adr"}, s_adr, e_adr);
        chk({nm, ".s_dat"}, s_dat_o, e_dat);
        chk({nm, ".s_we"}, {31'd0, s_we}, {31'd0, e_we});
        chk({nm, ".s_sel"}, {28'd0, s_sel}, {28'd0, e_sel});
        chk({nm, ".m0_dat"}, m0_dat_o, e_d0);
        chk({nm, ".m1_dat"}, m1_dat_o, e_d1);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fair0, fair1;
        fair0 = 0; fair1 = 0;
        m0_adr = 32'h0000_0040; m0_dat_i = 32'hA5A5_0000; m0_we = 1'b0; m0_sel = 4'hF; m0_stb = 1'b0;
        m1_adr = 32'h0000_0080; m1_dat_i = 32'h1234_5678; m1_we = 1'b0; m1_sel = 4'b0011; m1_stb = 1'b0;
        s_dat_i = 32'hDEAD_BEEF; s_ack = 1'b0;

        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        // m0 alone reads; 1-cycle slave
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 2'd1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        // continuous contention: grants 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 2'd1, 1'b1);
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1110, 2'd1, 1'b1);
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1);
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 2'd2, 1'b1);
            add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101, 2'd2, 1'b1);
        end
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0);  // stray ack in IDLE
        // m1 write while m0 idle
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        // m0 aborts, then m1 is served
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1101, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);

        foreach (vecs[i]) begin
            string nm;
            @(negedge clk);
            rst = vecs[i].rst; m0_stb = vecs[i].m0_stb; m1_stb = vecs[i].m1_stb;
            m1_we = vecs[i].m1_we; s_ack = vecs[i].s_ack;
            #1;
            nm = $sformatf("vec%0d", i);
            chk({nm, ".flags"}, {28'd0, s_stb, s_cyc, m0_ack, m1_ack}, {28'd0, vecs[i].e_flags});
            check_route(nm, vecs[i].src);
            chk({nm, ".err"}, {30'd0, m0_err, m1_err}, 32'd0);
            chk({nm, ".timeout"}, {31'd0, timeout}, 32'd0);
            if (vecs[i].fair && m0_ack) fair0++;
            if (vecs[i].fair && m1_ack) fair1++;
        end
        chk("fair.m0_acks", fair0, 32'd2);
        chk("fair.m1_acks", fair1, 32'd2);

        // async reset in the middle of a GNT0 transfer (leaves last grant = m0 before reset)
        @(negedge clk);
        m0_stb = 1'b1; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
        tick();
        #1;
        chk("arst.pre_stb", {31'd0, s_stb}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst.stb", {31'd0, s_stb}, 32'd0);
        chk("arst.cyc", {31'd0, s_cyc}, 32'd0);
        chk("arst.adr", s_adr, 32'd0);
        @(negedge clk);
        rst = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1;
        tick();
        #1;
        chk("arst.first_grant_adr", s_adr, 32'h0000_0040);
        s_ack = 1'b1;
        #1;
        chk("arst.first_grant_ack0", {31'd0, m0_ack}, 32'd1);
        chk("arst.first_grant_ack1", {31'd0, m1_ack}, 32'd0);
        @(negedge clk);
        m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
        // slave never acks m0: error in the 8th GNT0 cycle, sticky flag afterwards
        m0_stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            chk($sformatf("to.err_c%0d", k), {31'd0, m0_err}, {31'd0, (k == 8)});
            chk($sformatf("to.stb_c%0d", k), {31'd0, s_stb}, 32'd1);
            chk($sformatf("to.flag_c%0d", k), {31'd0, timeout}, 32'd0);
        end
        tick();
        m0_stb = 1'b0; m1_stb = 1'b1;
        #1;
        chk("to.idle_cyc", {31'd0, s_cyc}, 32'd0);
        chk("to.flag_set", {31'd0, timeout}, 32'd1);
        tick();
        s_ack = 1'b1;
        #1;
        chk("to.m1_ack", {31'd0, m1_ack}, 32'd1);
        chk("to.m1_adr", s_adr, 32'h0000_0080);
        chk("to.m1_err", {31'd0, m1_err}, 32'd0);
        tick();
        m1_stb = 1'b0; s_ack = 1'b0;
        #1;
        chk("to.flag_sticky", {31'd0, timeout}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // ack exactly in the 8th cycle wins over expiry
        m0_stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            s_ack = (k == 8);
            #1;
            chk($sformatf("tw.ack_c%0d", k), {31'd0, m0_ack}, {31'd0, (k == 8)});
            chk($sformatf("tw.err_c%0d", k), {31'd0, m0_err}, 32'd0);
        end
        tick();
        m0_stb = 1'b0; s_ack = 1'b0;
        #1;
        chk("tw.flag", {31'd0, timeout}, 32'd0);
`else
        // without the watchdog a silent slave holds the grant indefinitely
        m0_stb = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            #1;
            if (k % 10 == 0) begin
                chk($sformatf("nto.cyc_c%0d", k), {31'd0, s_cyc}, 32'd1);
                chk($sformatf("nto.err_c%0d", k), {30'd0, m0_err, timeout}, 32'd0);
            end
        end
        s_ack = 1'b1;
        #1;
        chk("nto.late_ack", {31'd0, m0_ack}, 32'd1);
        tick();
        m0_stb = 1'b0; s_ack = 1'b0;
        #1;
        chk("nto.idle", {31'd0, s_cyc}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
